// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmit user port among
// P_REQ_NUM requesters; a grant ends on last byte, burst limit or idle timeout.
module uart_tx_arbiter #(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_MAX_BURST       = 16,
  parameter int P_IDLE_TIMEOUT    = 64
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_user_tx_data,
  output logic                                   o_user_tx_valid,
  input  logic                                   i_user_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy
);

  localparam int W         = P_UART_DATA_WIDTH;
  localparam int IDX_W     = $clog2(P_REQ_NUM);
  localparam int BC_W      = (P_MAX_BURST > 0) ? $clog2(P_MAX_BURST + 1) : 1;
  localparam int IC_W      = (P_IDLE_TIMEOUT > 0) ? $clog2(P_IDLE_TIMEOUT + 1) : 1;
  localparam int BURST_LIM = (P_MAX_BURST > 0) ? P_MAX_BURST : 1;
  localparam int TO_LAST   = (P_IDLE_TIMEOUT > 0) ? P_IDLE_TIMEOUT - 1 : 0;

  localparam logic [BC_W:0]   BURST_LIM_V = BURST_LIM[BC_W:0];
  localparam logic [IC_W-1:0] TO_LAST_V   = TO_LAST[IC_W-1:0];

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_idx;
  logic [BC_W-1:0]  burst_cnt;
  logic [IC_W-1:0]  idle_cnt;

  logic             grant_active;
  logic             sel_valid;
  logic             sel_last;
  logic [W-1:0]     sel_data;
  logic             beat;
  logic             rel_burst;
  logic             rel_idle;
  logic             release_grant;
  logic [IDX_W-1:0] pick_idx;

  function automatic logic [BC_W-1:0] sat_inc_burst(input logic [BC_W-1:0] v);
    return (&v) ? v : v + BC_W'(1);
  endfunction

  function automatic logic [IC_W-1:0] sat_inc_idle(input logic [IC_W-1:0] v);
    return (&v) ? v : v + IC_W'(1);
  endfunction

  // First valid requester after the round-robin pointer, wrapping modulo P_REQ_NUM.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [P_REQ_NUM-1:0] vld,
                                               input logic [IDX_W-1:0]     last);
    logic [IDX_W-1:0] pick;
    int               idx;
    pick = last;
    for (int k = P_REQ_NUM; k >= 1; k--) begin
      idx = (int'(last) + k) % P_REQ_NUM;
      if (vld[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  assign grant_active = (state == ST_GRANT);
  assign pick_idx     = rr_pick(i_req_valid, last_idx);

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < P_REQ_NUM; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_valid = i_req_valid[k];
        sel_last  = i_req_last[k];
        sel_data  = i_req_data[k*W +: W];
      end
    end
  end

  assign beat          = grant_active & sel_valid & i_user_tx_ready;
  assign rel_burst     = (P_MAX_BURST != 0) && beat &&
                         (({1'b0, burst_cnt} + (BC_W+1)'(1)) == BURST_LIM_V);
  assign rel_idle      = (P_IDLE_TIMEOUT != 0) && grant_active && !sel_valid &&
                         (idle_cnt == TO_LAST_V);
  assign release_grant = (beat & sel_last) | rel_burst | rel_idle;

  // Output mux driven straight from the registered grant; the ready path is combinational.
  always_comb begin
    o_user_tx_valid = grant_active & sel_valid;
    o_user_tx_data  = grant_active ? sel_data : '0;
    o_req_ready     = (grant_active & i_user_tx_ready) ? o_grant : '0;
  end

  assign o_busy = grant_active;

  // Arbitration / grant-hold register stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_idx  <= IDX_W'(P_REQ_NUM - 1);
      o_grant   <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|i_req_valid) begin
            state     <= ST_GRANT;
            grant_idx <= pick_idx;
            last_idx  <= pick_idx;
            o_grant   <= P_REQ_NUM'(1) << pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
          end
        end
        default: begin
          if (beat) burst_cnt <= sat_inc_burst(burst_cnt);
          if (sel_valid) idle_cnt <= '0;
          else           idle_cnt <= sat_inc_idle(idle_cnt);
          if (release_grant) begin
            state   <= ST_IDLE;
            o_grant <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter: requester byte queues feed the DUT,
// a reference model predicts grants/beats into a scoreboard checked by a monitor.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;
  localparam int TO = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   i_req_valid;
  logic [N*W-1:0] i_req_data;
  logic [N-1:0]   i_req_last;
  logic [N-1:0]   o_req_ready;
  logic [W-1:0]   o_user_tx_data;
  logic           o_user_tx_valid;
  logic           i_user_tx_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .P_REQ_NUM(N), .P_UART_DATA_WIDTH(W), .P_MAX_BURST(MB), .P_IDLE_TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_user_tx_data(o_user_tx_data),
    .o_user_tx_valid(o_user_tx_valid), .i_user_tx_ready(i_user_tx_ready),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  typedef struct packed {
    logic [2:0]   idx;
    logic         last;
    logic [W-1:0] data;
  } ent_t;

  ent_t src_q[$];   // bytes waiting at the requesters, in per-requester order
  ent_t sb_q[$];    // predicted transfers
  ent_t sb_e;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state: owner (-1 = idle), round-robin pointer, counters
  int m_owner, m_ptr, m_burst, m_idle;
  int gate_pct, rdy_mode;

  logic [N-1:0] exp_grant, exp_ready;
  logic         exp_busy, exp_valid;
  logic [W-1:0] exp_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int head_of(input int k);
    for (int i = 0; i < src_q.size(); i++)
      if (int'(src_q[i].idx) == k) return i;
    return -1;
  endfunction

  task automatic push_pkt(input int k, input int len, input int base, input bit with_last);
    ent_t e;
    for (int i = 0; i < len; i++) begin
      e.idx  = 3'(k);
      e.last = with_last && (i == len - 1);
      e.data = W'(base + i);
      src_q.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = N - 1; m_burst = 0; m_idle = 0;
  endtask

  // Apply the arbitration rules to the inputs of the cycle that just ended.
  task automatic model_advance();
    int  g, h;
    bit  rel, found;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int s = 1; s <= N; s++) begin
        if (!found && i_req_valid[(m_ptr + s) % N]) begin
          found   = 1'b1;
          m_owner = (m_ptr + s) % N;
        end
      end
      if (found) begin
        m_ptr = m_owner; m_burst = 0; m_idle = 0;
      end
    end else begin
      g = m_owner; rel = 1'b0;
      if (i_req_valid[g] && i_user_tx_ready) begin
        h = head_of(g);
        if (h >= 0) src_q.delete(h);
        m_burst++;
        if (i_req_last[g]) rel = 1'b1;
        if (MB != 0 && m_burst == MB) rel = 1'b1;
      end
      if (i_req_valid[g]) m_idle = 0;
      else begin
        if (TO != 0 && m_idle == TO - 1) rel = 1'b1;
        m_idle++;
      end
      if (rel) m_owner = -1;
    end
  endtask

  task automatic drive();
    int             h;
    logic [N-1:0]   v, l;
    logic [N*W-1:0] d;
    ent_t           e;
    for (int k = 0; k < N; k++) begin
      h = head_of(k);
      if (h >= 0) begin
        v[k]         = ($urandom_range(99) < gate_pct);
        d[k*W +: W]  = src_q[h].data;
        l[k]         = src_q[h].last;
      end else begin
        v[k]         = 1'b0;
        d[k*W +: W]  = W'($urandom);
        l[k]         = 1'($urandom);
      end
    end
    i_req_valid = v; i_req_data = d; i_req_last = l;
    case (rdy_mode)
      0:       i_user_tx_ready = 1'b1;
      1:       i_user_tx_ready = ~i_user_tx_ready;
      default: i_user_tx_ready = 1'($urandom_range(1));
    endcase
    exp_grant = '0; exp_busy = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_ready = '0;
    if (m_owner >= 0) begin
      exp_grant = N'(1) << m_owner;
      exp_busy  = 1'b1;
      exp_valid = v[m_owner];
      exp_data  = d[m_owner*W +: W];
      exp_ready = i_user_tx_ready ? exp_grant : '0;
      if (v[m_owner] && i_user_tx_ready) begin
        e.idx = 3'(m_owner); e.last = l[m_owner]; e.data = d[m_owner*W +: W];
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    model_advance();
    drive();
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((src_q.size() != 0 || m_owner >= 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(n < budget), 64'd1);
  endtask

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("grant", 64'(o_grant), 64'(exp_grant));
      chk("busy", 64'(o_busy), 64'(exp_busy));
      chk("tx_valid", 64'(o_user_tx_valid), 64'(exp_valid));
      chk("tx_data", 64'(o_user_tx_data), 64'(exp_data));
      chk("req_ready", 64'(o_req_ready), 64'(exp_ready));
      if (o_user_tx_valid && i_user_tx_ready) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: beat data %0h with nothing expected", o_user_tx_data);
        end else begin
          sb_e = sb_q.pop_front();
          chk("sb_data", 64'(o_user_tx_data), 64'(sb_e.data));
          chk("sb_owner", 64'(o_grant), 64'(N'(1) << sb_e.idx));
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0;
    i_req_valid = '0; i_req_data = '0; i_req_last = '0; i_user_tx_ready = 1'b1;
    gate_pct = 100; rdy_mode = 0;
    model_reset();
    exp_grant = '0; exp_busy = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_ready = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_valid", 64'(o_user_tx_valid), 64'd0);
    chk("rst_ready", 64'(o_req_ready), 64'd0);
    chk("rst_data", 64'(o_user_tx_data), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Every requester holding 1-byte packets: order 0,1,2,3,0,...
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push_pkt(k, 1, 16 * k + r, 1'b1);
    drain("rr_all", 100);

    // Requester 1, three bytes 0x41..0x43
    push_pkt(1, 3, 'h41, 1'b1);
    drain("single", 50);

    // Burst limit: requester 2 with 10 bytes, requester 3 with 8 bytes
    push_pkt(2, 10, 'h80, 1'b1);
    push_pkt(3, 8, 'hC0, 1'b1);
    drain("burst", 100);

    // Idle timeout: requester 0 stops without last; requester 1 waits
    push_pkt(0, 1, 'h11, 1'b0);
    push_pkt(1, 2, 'h21, 1'b1);
    drain("timeout", 100);

    // Ready toggling during a 5-byte packet from requester 3
    rdy_mode = 1;
    push_pkt(3, 5, 'h31, 1'b1);
    drain("toggle", 100);

    // Random traffic
    rdy_mode = 2; gate_pct = 70;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(99) < 12)
        push_pkt($urandom_range(N - 1), $urandom_range(1, 7), $urandom_range(255), 1'($urandom_range(3) != 0));
      step();
    end
    gate_pct = 100;
    drain("random", 3000);

    // Reset in the middle of a packet from requester 1
    rdy_mode = 0;
    push_pkt(1, 10, 'h60, 1'b1);
    n = 0;
    while (m_owner != 1 && n < 20) begin step(); n++; end
    chk("rst_mid_owner", 64'(m_owner == 1), 64'd1);
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant", 64'(o_grant), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_valid", 64'(o_user_tx_valid), 64'd0);
    chk("mid_rst_ready", 64'(o_req_ready), 64'd0);
    chk("mid_rst_data", 64'(o_user_tx_data), 64'd0);
    src_q.delete();
    sb_q.delete();
    model_reset();
    i_req_valid = '0; i_req_last = '0;
    exp_grant = '0; exp_busy = 1'b0; exp_valid = 1'b0; exp_data = '0; exp_ready = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    push_pkt(0, 1, 'hA0, 1'b1);
    push_pkt(1, 1, 'hA1, 1'b1);
    step();
    step();
    #2;
    chk("rst_rr_first", 64'(o_grant), 64'b0001);
    drain("post_reset", 50);

    repeat (3) step();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
